// File: rtl/timer_counter_if.sv
// Register bus between the system bridge and one timer: word address, write strobe/data, read data, irq.
// Latency: none, plain wires.
// Backpressure: none, the bridge may access the bus on every cycle.
interface timer_counter_if;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counting timer: one-shot/auto-reload, maskable irq. Optional TC_IRQ_STATUS_EN maps STATUS at offset 3.
// Latency: rdata is combinational; counting starts on the second edge after EN is written.
// Backpressure: none, every register write is accepted in the cycle it is strobed.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;
    logic [31:0]      rdata;
    logic             unused_ok;

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            IDLE: if (en_q) state_d = LOAD;
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                state_d = IDLE;
                // Only mode 1 reloads; modes 0, 2 and 3 are one-shot.
                if (mode_q == 2'd1) irq_flag_d = 1'b0;
                else                en_d       = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Register writes are applied last so they override the FSM in the same edge.
        if (bus.we) begin
            case (bus.addr[1:0])
                OFF_CTRL: begin
                    en_d       = bus.wdata[0];
                    mode_d     = bus.wdata[2:1];
                    im_d       = bus.wdata[3];
                    irq_flag_d = 1'b0;
                end
                OFF_PRESET: begin
                    preset_d   = bus.wdata[CNT_W-1:0];
                    irq_flag_d = 1'b0;
                end
`ifdef TC_IRQ_STATUS_EN
                OFF_STATUS: if (bus.wdata[0]) irq_flag_d = 1'b0;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.addr[1:0])
            OFF_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
            OFF_PRESET: rdata = 32'(preset_q);
            OFF_COUNT:  rdata = 32'(count_q);
`ifdef TC_IRQ_STATUS_EN
            OFF_STATUS: rdata = {31'd0, irq_flag_q};
`else
            OFF_STATUS: rdata = 32'd0;
`endif
            default:    rdata = 32'd0;
        endcase
    end

    assign bus.rdata = rdata;
    assign bus.irq   = irq_flag_q & im_q;

    // The bridge does the range decode; upper address bits are don't-care here.
    assign unused_ok = ^{bus.addr[29:2], bus.wdata};
endmodule

// File: tb/tb_timer_counter.sv
// Scoreboarded bench for timer_counter: directed scenarios plus random register traffic against a
// deadline-based reference model; honours TC_IRQ_STATUS_EN.
module tb_timer_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_counter_if bus ();
    timer_counter #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic        irq;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: a run is described by its start edge and the edge at which it fires.
    logic        m_en, m_im, m_flag, m_busy;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    longint      m_n, m_t0, m_fire;

    task automatic model_reset();
        m_en = 0; m_im = 0; m_flag = 0; m_busy = 0; m_mode = 0;
        m_preset = 0; m_count = 0; m_t0 = 0; m_fire = 0;
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] off);
        case (off)
            2'd0: return {28'd0, m_im, m_mode, m_en};
            2'd1: return m_preset;
            2'd2: return m_count;
`ifdef TC_IRQ_STATUS_EN
            default: return {31'd0, m_flag};
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    task automatic model_edge(input logic [1:0] off, input logic w, input logic [31:0] d);
        m_n++;
        if (!m_busy) begin
            if (m_en) begin
                m_busy = 1;
                m_t0   = m_n;
            end
        end else if (m_n == m_t0 + 1) begin
            m_count = m_preset;
            m_fire  = m_n + ((m_preset == 0) ? 64'sd1 : longint'(m_preset));
        end else if (m_n <= m_fire) begin
            if (!m_en) m_busy = 0;
            else begin
                m_count = 32'(m_fire - m_n);
                if (m_n == m_fire) m_flag = 1;
            end
        end else begin
            m_busy = 0;
            if (m_mode == 2'd1) m_flag = 0;
            else                m_en   = 0;
        end
        if (w) begin
            case (off)
                2'd0: begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0; end
                2'd1: begin m_preset = d; m_flag = 0; end
`ifdef TC_IRQ_STATUS_EN
                2'd3: if (d[0]) m_flag = 0;
`endif
                default: ;
            endcase
        end
    endtask

    task automatic push_expect(input logic [1:0] off);
        exp_t e;
        e.irq   = m_flag & m_im;
        e.rdata = model_rdata(off);
        exp_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic cycle(input logic [1:0] off, input logic w, input logic [31:0] d);
        logic [29:0] a;
        a = 30'($urandom());
        a[1:0] = off;
        @(negedge clk);
        bus.addr = a; bus.we = w; bus.wdata = d;
        push_expect(off);
        @(posedge clk);
        if (rst_n) model_edge(off, w, d);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) cycle(2'($urandom_range(0, 3)), 1'b0, $urandom());
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        cycle(off, 1'b1, d);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("irq", {31'd0, bus.irq}, {31'd0, e.irq});
                check("rdata", bus.rdata, e.rdata);
            end
        end
    end

    initial begin
        m_n = 0;
        model_reset();
        bus.addr = '0; bus.we = 0; bus.wdata = '0;

        for (int k = 0; k < 4; k++) cycle(2'(k), 1'b0, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // One-shot, PRESET=5; afterwards a CTRL write drops irq.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        rd(12);
        wr(2'd0, 32'h8);
        rd(3);

        // Auto-reload, PRESET=3, then disable.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int i = 0; i < 22; i++) cycle(2'd2, 1'b0, 32'd0);
        wr(2'd0, 32'h2);
        rd(12);

        // Masked one-shot: flag sets, irq stays low, EN self-clears.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        rd(10);

        // Pause mid-count, ignored COUNT write, re-enable reloads.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 40 && m_count != 32'd7; i++) cycle(2'd2, 1'b0, 32'd0);
        wr(2'd0, 32'h8);
        rd(4);
        wr(2'd2, 32'h55);
        cycle(2'd2, 1'b0, 32'd0);
        wr(2'd0, 32'h9);
        rd(16);

        // PRESET=0 acts like 1.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        rd(6);

        // Interrupt acknowledge through offset 3.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        rd(6);
        cycle(2'd3, 1'b0, 32'd0);
        wr(2'd3, 32'd0);
        cycle(2'd3, 1'b0, 32'd0);
        wr(2'd3, 32'd1);
        cycle(2'd3, 1'b0, 32'd0);
        rd(2);

        // Asynchronous reset mid-count, observed before any clock edge.
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        rd(8);
        @(posedge clk);
        #2;
        bus.addr = 30'd1; bus.we = 1'b0;
        rst_n = 1'b0;
        model_reset();
        push_expect(2'd1);
        for (int k = 0; k < 4; k++) cycle(2'(k), 1'b0, 32'd0);
        bus.we = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;

        // Random register traffic.
        for (int i = 0; i < 1500; i++) begin
            int          roll;
            logic [31:0] d;
            roll = $urandom_range(0, 15);
            d = $urandom();
            if (roll == 0) begin
                d[0] = ($urandom_range(0, 3) != 0);
                wr(2'd0, d);
            end else if (roll == 1) begin
                wr(2'd1, 32'($urandom_range(0, 9)));
            end else if (roll == 2) begin
                wr(2'($urandom_range(2, 3)), d);
            end else begin
                rd(1);
            end
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
